text_buffer_writer: RTL and testbench

//  Producer side of the character RAM that the VGA text renderer reads. Takes decoded
//  PS/2 set-2 scancode bytes and filters out break sequences (F0 xx, E0 F0 xx). Writes

---
 rtl/text_buffer_writer.sv | 172 +++++++++++++++++
 tb/tb_text_buffer_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// Producer side of the VGA text RAM: filters PS/2 set-2 break sequences, writes printable
// codes at the document pointer, handles editing keys and tracks the first visible row.
module text_buffer_writer #(
  parameter int RAM_SIZE   = 512,
  parameter int ROW_LENGTH = 18,
  parameter int COL_LENGTH = 29,
  parameter int ADDR_W     = 10
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iScan_valid,
  input  logic [7:0]        iScan_code,
  output logic              oWr_en,
  output logic [ADDR_W-1:0] oWr_addr,
  output logic [7:0]        oWr_data,
  output logic [ADDR_W-1:0] oDoc_ptr,
  output logic [ADDR_W-1:0] oScroll,
  output logic              oBusy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] WA    = ADDR_W'(RAM_SIZE - 2);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(RAM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ROW_L = ADDR_W'(ROW_LENGTH);
  localparam logic [ADDR_W-1:0] COL_L = ADDR_W'(COL_LENGTH);

  localparam logic [255:0] PRINTABLE = {
    8'h70, 8'h49, 8'h41, 8'h52, 8'h16, 8'h1C, 8'h32, 8'h21,
    8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42,
    8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29
  };

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W-1:0] scroll_reg;
  logic [ADDR_W-1:0] fill_end_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              brk_reg;
  logic              ext_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;

  logic [31:0]       print_hit;
  logic              is_printable;
  logic [ADDR_W-1:0] ptr_row;
  logic [ADDR_W-1:0] row_end;
  logic [ADDR_W-1:0] enter_end;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_print
      assign print_hit[gi] = (iScan_code == PRINTABLE[gi*8 +: 8]);
    end
  endgenerate

  assign is_printable = |print_hit;
  assign ptr_row      = ptr_reg / ROW_L;
  assign row_end      = (ptr_row + ONE) * ROW_L;
  assign enter_end    = (row_end > WA) ? WA : row_end;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      scroll_reg   <= '0;
      fill_end_reg <= '0;
      clr_addr_reg <= '0;
      brk_reg      <= 1'b0;
      ext_reg      <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= 8'h00;
    end else begin
      wr_en_reg <= 1'b0;

      // Scroll follows the registered pointer, so it lags pointer moves by one cycle.
      if (ptr_row >= scroll_reg + COL_L)
        scroll_reg <= ptr_row - COL_L + ONE;
      else if (ptr_row < scroll_reg)
        scroll_reg <= ptr_row;

      case (state_reg)
        S_IDLE: begin
          if (iScan_valid) begin
            if (brk_reg) begin
              brk_reg <= 1'b0;
              ext_reg <= 1'b0;
            end else if (iScan_code == 8'hF0) begin
              brk_reg <= 1'b1;
            end else if (iScan_code == 8'hE0) begin
              ext_reg <= 1'b1;
            end else begin
              ext_reg <= 1'b0;
              if (ext_reg) begin
                if (iScan_code == 8'h6B && ptr_reg != '0)
                  ptr_reg <= ptr_reg - ONE;
                else if (iScan_code == 8'h74 && ptr_reg < WA)
                  ptr_reg <= ptr_reg + ONE;
              end else if (is_printable) begin
                if (ptr_reg < WA) begin
                  wr_en_reg   <= 1'b1;
                  wr_addr_reg <= ptr_reg;
                  wr_data_reg <= iScan_code;
                  ptr_reg     <= ptr_reg + ONE;
                end
              end else begin
                case (iScan_code)
                  8'h66: begin
                    if (ptr_reg != '0) begin
                      wr_en_reg   <= 1'b1;
                      wr_addr_reg <= ptr_reg - ONE;
                      wr_data_reg <= 8'h00;
                      ptr_reg     <= ptr_reg - ONE;
                    end
                  end
                  8'h5A: begin
                    if (ptr_reg < enter_end) begin
                      fill_end_reg <= enter_end;
                      state_reg    <= S_FILL;
                    end
                  end
                  8'h76: begin
                    clr_addr_reg <= '0;
                    state_reg    <= S_CLEAR;
                  end
                  default: ;
                endcase
              end
            end
          end
        end

        S_FILL: begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= ptr_reg;
          wr_data_reg <= 8'h00;
          ptr_reg     <= ptr_reg + ONE;
          if (ptr_reg + ONE == fill_end_reg)
            state_reg <= S_IDLE;
        end

        S_CLEAR: begin
          wr_en_reg    <= 1'b1;
          wr_addr_reg  <= clr_addr_reg;
          wr_data_reg  <= 8'h00;
          clr_addr_reg <= clr_addr_reg + ONE;
          // Sweep covers the null cell too; cursor and view return home afterwards.
          if (clr_addr_reg == LAST) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            scroll_reg <= '0;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign oWr_en   = wr_en_reg;
  assign oWr_addr = wr_addr_reg;
  assign oWr_data = wr_data_reg;
  assign oDoc_ptr = ptr_reg;
  assign oScroll  = scroll_reg;
  assign oBusy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: a vector table for single-key behaviour plus
// hand-written sequences for FILL, pointer limits, scrolling, CLEAR and reset mid-CLEAR.
module tb_text_buffer_writer;

  logic       clk;
  logic       rst_n;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [9:0] doc_ptr;
  logic [9:0] scroll;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  // Fewer visible rows so the last reachable row (28) forces a scroll.
  text_buffer_writer #(
    .RAM_SIZE(512), .ROW_LENGTH(18), .COL_LENGTH(28), .ADDR_W(10)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iScan_valid(scan_valid), .iScan_code(scan_code),
    .oWr_en(wr_en), .oWr_addr(wr_addr), .oWr_data(wr_data),
    .oDoc_ptr(doc_ptr), .oScroll(scroll), .oBusy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       exp_wr;
    logic [9:0] exp_addr;
    logic [7:0] exp_data;
    logic [9:0] exp_ptr;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [0:NV-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns on the falling edge right after the clock edge that sampled the byte.
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = c;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy === 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic enter_row();
    send(8'h5A);
    wait_idle(40);
  endtask

  initial begin
    int good;
    tbl[0]  = '{8'h1C, 1'b1, 10'd0, 8'h1C, 10'd1};
    tbl[1]  = '{8'hF0, 1'b0, 10'd0, 8'h00, 10'd1};
    tbl[2]  = '{8'h1C, 1'b0, 10'd0, 8'h00, 10'd1};
    tbl[3]  = '{8'hE0, 1'b0, 10'd0, 8'h00, 10'd1};
    tbl[4]  = '{8'h74, 1'b0, 10'd0, 8'h00, 10'd2};
    tbl[5]  = '{8'hE0, 1'b0, 10'd0, 8'h00, 10'd2};
    tbl[6]  = '{8'h6B, 1'b0, 10'd0, 8'h00, 10'd1};
    tbl[7]  = '{8'h32, 1'b1, 10'd1, 8'h32, 10'd2};
    tbl[8]  = '{8'h21, 1'b1, 10'd2, 8'h21, 10'd3};
    tbl[9]  = '{8'h29, 1'b1, 10'd3, 8'h29, 10'd4};
    tbl[10] = '{8'h66, 1'b1, 10'd3, 8'h00, 10'd3};
    tbl[11] = '{8'h66, 1'b1, 10'd2, 8'h00, 10'd2};
    tbl[12] = '{8'h66, 1'b1, 10'd1, 8'h00, 10'd1};
    tbl[13] = '{8'h66, 1'b1, 10'd0, 8'h00, 10'd0};
    tbl[14] = '{8'h66, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[15] = '{8'hE0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[16] = '{8'h6B, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[17] = '{8'hE0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[18] = '{8'hF0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[19] = '{8'h74, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[20] = '{8'h05, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[21] = '{8'hE0, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[22] = '{8'h1C, 1'b0, 10'd0, 8'h00, 10'd0};
    tbl[23] = '{8'h1C, 1'b1, 10'd0, 8'h1C, 10'd1};
    tbl[24] = '{8'h70, 1'b1, 10'd1, 8'h70, 10'd2};
    tbl[25] = '{8'h4D, 1'b1, 10'd2, 8'h4D, 10'd3};
    tbl[26] = '{8'h15, 1'b1, 10'd3, 8'h15, 10'd4};
    tbl[27] = '{8'h3C, 1'b1, 10'd4, 8'h3C, 10'd5};

    rst_n      = 1'b0;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ptr", doc_ptr, 0);
    check("rst_scroll", scroll, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      send(tbl[i].code);
      check($sformatf("v%0d_wr_en", i), wr_en, tbl[i].exp_wr);
      if (tbl[i].exp_wr) begin
        check($sformatf("v%0d_addr", i), wr_addr, tbl[i].exp_addr);
        check($sformatf("v%0d_data", i), wr_data, tbl[i].exp_data);
      end
      check($sformatf("v%0d_ptr", i), doc_ptr, tbl[i].exp_ptr);
      $display("vector %0d: code %h wr %0b addr %0d data %h ptr %0d",
               i, tbl[i].code, wr_en, wr_addr, wr_data, doc_ptr);
    end

    // Enter at ptr 5: thirteen blank writes 5..17; an F0 during FILL must be dropped.
    send(8'h5A);
    check("fill_busy_start", busy, 1);
    check("fill_no_write_yet", wr_en, 0);
    for (int k = 1; k <= 13; k++) begin
      if (k == 3) begin
        scan_valid = 1'b1;
        scan_code  = 8'hF0;
      end
      @(negedge clk);
      scan_valid = 1'b0;
      check($sformatf("fill%0d_wr_en", k), wr_en, 1);
      check($sformatf("fill%0d_addr", k), wr_addr, 10'(4 + k));
      check($sformatf("fill%0d_data", k), wr_data, 8'h00);
      check($sformatf("fill%0d_busy", k), busy, (k < 13) ? 1 : 0);
    end
    check("fill_end_ptr", doc_ptr, 18);
    $display("fill: ptr %0d busy %0b", doc_ptr, busy);
    send(8'h1C);
    check("post_fill_wr_en", wr_en, 1);
    check("post_fill_addr", wr_addr, 18);
    check("post_fill_ptr", doc_ptr, 19);

    for (int i = 0; i < 26; i++) enter_row();
    check("rows_ptr", doc_ptr, 486);
    check("rows_scroll", scroll, 0);
    for (int i = 0; i < 17; i++) begin
      send(8'hE0);
      send(8'h74);
    end
    check("right_ptr", doc_ptr, 503);

    // Typing into row 28 scrolls the view one cycle after the pointer moves.
    send(8'h1C);
    check("scr_wr_addr", wr_addr, 503);
    check("scr_ptr", doc_ptr, 504);
    check("scr_lag", scroll, 0);
    @(negedge clk);
    check("scr_update", scroll, 1);
    $display("scroll: ptr %0d scroll %0d", doc_ptr, scroll);

    // Enter on the last row stops at WA.
    send(8'h5A);
    check("wa_fill_busy", busy, 1);
    wait_idle(40);
    check("wa_fill_ptr", doc_ptr, 510);
    check("wa_fill_last_addr", wr_addr, 509);

    send(8'h1C);
    check("wa_type_wr", wr_en, 0);
    check("wa_type_ptr", doc_ptr, 510);
    send(8'hE0);
    send(8'h74);
    check("wa_right_ptr", doc_ptr, 510);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    check("wa_brk_wr", wr_en, 0);
    check("wa_brk_ptr", doc_ptr, 510);
    send(8'h5A);
    check("wa_enter_busy", busy, 0);
    check("wa_enter_wr", wr_en, 0);
    send(8'h66);
    check("wa_bs_addr", wr_addr, 509);
    check("wa_bs_ptr", doc_ptr, 509);
    send(8'hE0);
    send(8'h74);
    check("wa_back_ptr", doc_ptr, 510);

    // ESC clears every cell including the null cell.
    send(8'h76);
    check("clr_busy_start", busy, 1);
    check("clr_no_write_yet", wr_en, 0);
    good = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_addr === 10'(k) && wr_data === 8'h00) good++;
    end
    check("clr_writes", good, 512);
    check("clr_busy_end", busy, 0);
    check("clr_ptr", doc_ptr, 0);
    check("clr_scroll", scroll, 0);
    @(negedge clk);
    check("clr_no_extra_write", wr_en, 0);
    $display("clear: %0d good writes, ptr %0d scroll %0d", good, doc_ptr, scroll);

    // Moving the cursor above the first visible row scrolls back.
    for (int i = 0; i < 28; i++) enter_row();
    check("rows28_ptr", doc_ptr, 504);
    @(negedge clk);
    check("rows28_scroll", scroll, 1);
    for (int i = 0; i < 486; i++) begin
      send(8'hE0);
      send(8'h6B);
    end
    @(negedge clk);
    check("left_row1_ptr", doc_ptr, 18);
    check("left_row1_scroll", scroll, 1);
    send(8'hE0);
    send(8'h6B);
    check("left_row0_ptr", doc_ptr, 17);
    @(negedge clk);
    check("left_row0_scroll", scroll, 0);

    // Reset in the middle of CLEAR drops all outputs at once.
    send(8'h76);
    repeat (100) @(negedge clk);
    check("midclr_active", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("midclr_rst_wr_en", wr_en, 0);
    check("midclr_rst_addr", wr_addr, 0);
    check("midclr_rst_ptr", doc_ptr, 0);
    check("midclr_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C);
    check("after_rst_addr", wr_addr, 0);
    check("after_rst_ptr", doc_ptr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
